// File: rtl/sgmii_reg_init_master.sv
// Wishbone initiator that boots the SGMII PCS register block (mode, link timer,
// Reg4, Reg0), polls status for link-up, then serves single host register accesses.
module sgmii_reg_init_master #(
    parameter logic [15:0] pModeReg    = 16'h0001,
    parameter logic [20:0] pLinkTimer  = 21'h30D40,
    parameter logic [15:0] pReg4       = 16'h0000,
    parameter logic [15:0] pReg0       = 16'h1200,
    parameter int          pAckTimeout = 16,
    parameter int          pPollGap    = 1024,
    parameter int          pPollMax    = 255
) (
    input  logic        i_Clk,
    input  logic        i_RstLogic_L,
    output logic        o_Cyc,
    output logic        o_Stb,
    output logic        o_WEn,
    output logic [7:0]  o8_Addr,
    output logic [31:0] o32_WrData,
    input  logic [31:0] i32_RdData,
    input  logic        i_Ack,
    input  logic        i_CmdValid,
    output logic        o_CmdReady,
    input  logic        i_CmdWEn,
    input  logic [4:0]  i5_CmdReg,
    input  logic [15:0] i16_CmdWrData,
    output logic        o_RspValid,
    output logic [15:0] o16_RspData,
    output logic        o_RspErr,
    output logic        o_BootDone,
    output logic        o_BootErr,
    output logic        o_LinkUp
);

    typedef enum logic [3:0] {
        BOOT_ISSUE, BOOT_WAIT, BOOT_GAP, POLL_GAP, POLL_ISSUE, POLL_WAIT,
        DONE, READY, HOST_WAIT, HOST_RSP
    } state_t;

    localparam logic [15:0] ACK_LAST  = 16'(pAckTimeout - 1);
    localparam logic [15:0] GAP_LAST  = 16'(pPollGap - 1);
    localparam logic [7:0]  POLL_LAST = 8'(pPollMax);
    localparam logic [2:0]  BOOT_LAST = 3'd4;

    state_t      state_q, state_d;
    logic        stb_q, stb_d;
    logic        wen_q, wen_d;
    logic [4:0]  reg_q, reg_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  poll_q, poll_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        boot_done_q, boot_done_d;
    logic        boot_err_q, boot_err_d;
    logic        link_up_q, link_up_d;

    logic        ack_hit, ack_tmo, link_ok;
    logic [7:0]  poll_inc;
    logic [4:0]  boot_reg;
    logic [15:0] boot_data;
    logic        unused_rd_hi;

    assign unused_rd_hi = ^i32_RdData[31:16];

    // Ack wins over a timeout landing in the same cycle; Ack with Stb low is ignored.
    assign ack_hit  = stb_q & i_Ack;
    assign ack_tmo  = stb_q & ~i_Ack & (cnt_q == ACK_LAST);
    assign link_ok  = i32_RdData[2] & (i32_RdData[5] | ~pReg0[12]);
    assign poll_inc = poll_q + 8'd1;

    always_comb begin
        boot_reg  = 5'h00;
        boot_data = pReg0;
        unique case (idx_q)
            3'd0:    begin boot_reg = 5'h1F; boot_data = pModeReg;                  end
            3'd1:    begin boot_reg = 5'h08; boot_data = pLinkTimer[15:0];          end
            3'd2:    begin boot_reg = 5'h09; boot_data = {11'h0, pLinkTimer[20:16]}; end
            3'd3:    begin boot_reg = 5'h04; boot_data = pReg4;                     end
            default: begin boot_reg = 5'h00; boot_data = pReg0;                     end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_RstLogic_L) begin
            state_q     <= BOOT_ISSUE;
            stb_q       <= 1'b0;
            wen_q       <= 1'b0;
            reg_q       <= 5'h00;
            wdata_q     <= 16'h0000;
            cnt_q       <= 16'h0000;
            idx_q       <= 3'd0;
            poll_q      <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_err_q   <= 1'b0;
            boot_done_q <= 1'b0;
            boot_err_q  <= 1'b0;
            link_up_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stb_q       <= stb_d;
            wen_q       <= wen_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            poll_q      <= poll_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            boot_done_q <= boot_done_d;
            boot_err_q  <= boot_err_d;
            link_up_q   <= link_up_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT_ISSUE: state_d = BOOT_WAIT;
            BOOT_WAIT:  if (ack_hit) state_d = BOOT_GAP;
                        else if (ack_tmo) state_d = DONE;
            BOOT_GAP:   state_d = (idx_q == BOOT_LAST) ? POLL_GAP : BOOT_ISSUE;
            POLL_GAP:   if (cnt_q == GAP_LAST) state_d = POLL_ISSUE;
            POLL_ISSUE: state_d = POLL_WAIT;
            POLL_WAIT:  if (ack_hit) state_d = (link_ok || poll_inc == POLL_LAST) ? DONE : POLL_GAP;
                        else if (ack_tmo) state_d = DONE;
            DONE:       state_d = READY;
            READY:      if (i_CmdValid) state_d = HOST_WAIT;
            HOST_WAIT:  if (ack_hit || ack_tmo) state_d = HOST_RSP;
            HOST_RSP:   state_d = READY;
            default:    state_d = BOOT_ISSUE;
        endcase
    end

    always_comb begin
        stb_d       = stb_q;
        wen_d       = wen_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        poll_d      = poll_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        boot_done_d = boot_done_q;
        boot_err_d  = boot_err_q;
        link_up_d   = link_up_q;
        unique case (state_q)
            BOOT_ISSUE: begin
                stb_d   = 1'b1;
                wen_d   = 1'b1;
                reg_d   = boot_reg;
                wdata_d = boot_data;
                cnt_d   = 16'h0000;
            end
            BOOT_WAIT: begin
                if (ack_hit) stb_d = 1'b0;
                else if (ack_tmo) begin
                    stb_d      = 1'b0;
                    boot_err_d = 1'b1;
                end else cnt_d = cnt_q + 16'd1;
            end
            BOOT_GAP: begin
                idx_d = idx_q + 3'd1;
                cnt_d = 16'h0000;
            end
            POLL_GAP: cnt_d = cnt_q + 16'd1;
            POLL_ISSUE: begin
                stb_d   = 1'b1;
                wen_d   = 1'b0;
                reg_d   = 5'h01;
                wdata_d = 16'h0000;
                cnt_d   = 16'h0000;
            end
            POLL_WAIT: begin
                if (ack_hit) begin
                    stb_d     = 1'b0;
                    cnt_d     = 16'h0000;
                    link_up_d = link_ok;
                    if (!link_ok) begin
                        poll_d = poll_inc;
                        if (poll_inc == POLL_LAST) boot_err_d = 1'b1;
                    end
                end else if (ack_tmo) begin
                    stb_d      = 1'b0;
                    boot_err_d = 1'b1;
                end else cnt_d = cnt_q + 16'd1;
            end
            DONE: boot_done_d = 1'b1;
            READY: begin
                // Request fields are captured here, so later host changes are harmless.
                if (i_CmdValid) begin
                    stb_d   = 1'b1;
                    wen_d   = i_CmdWEn;
                    reg_d   = i5_CmdReg;
                    wdata_d = i_CmdWEn ? i16_CmdWrData : 16'h0000;
                    cnt_d   = 16'h0000;
                end
            end
            HOST_WAIT: begin
                if (ack_hit) begin
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = wen_q ? 16'h0000 : i32_RdData[15:0];
                    if (!wen_q && reg_q == 5'h01) link_up_d = link_ok;
                end else if (ack_tmo) begin
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = 16'h0000;
                end else cnt_d = cnt_q + 16'd1;
            end
            default: ;
        endcase
    end

    assign o_Cyc       = stb_q;
    assign o_Stb       = stb_q;
    assign o_WEn       = wen_q;
    assign o8_Addr     = {1'b0, reg_q, 2'b00};
    assign o32_WrData  = {16'h0000, wdata_q};
    assign o_CmdReady  = (state_q == READY);
    assign o_RspValid  = rsp_valid_q;
    assign o16_RspData = rsp_data_q;
    assign o_RspErr    = rsp_err_q;
    assign o_BootDone  = boot_done_q;
    assign o_BootErr   = boot_err_q;
    assign o_LinkUp    = link_up_q;

endmodule

// File: tb/tb_sgmii_reg_init_master.sv
// Bench for sgmii_reg_init_master: a behavioural Wishbone slave with a bus log,
// directed boot/host scenarios plus randomized status and host traffic.
module tb_sgmii_reg_init_master;

    localparam logic [15:0] P_MODE = 16'h0001;
    localparam logic [20:0] P_LT   = 21'h30D40;
    localparam logic [15:0] P_REG4 = 16'h0000;
    localparam logic [15:0] P_REG0 = 16'h1200;
    localparam int          P_TMO  = 16;
    localparam int          P_GAP  = 24;
    localparam int          P_PMAX = 5;

    logic        i_Clk = 1'b0;
    logic        i_RstLogic_L = 1'b0;
    logic        o_Cyc, o_Stb, o_WEn;
    logic [7:0]  o8_Addr;
    logic [31:0] o32_WrData;
    logic [31:0] rd = 32'h0;
    logic        ack = 1'b0;
    logic        i_CmdValid = 1'b0;
    logic        o_CmdReady;
    logic        i_CmdWEn = 1'b0;
    logic [4:0]  i5_CmdReg = 5'h0;
    logic [15:0] i16_CmdWrData = 16'h0;
    logic        o_RspValid;
    logic [15:0] o16_RspData;
    logic        o_RspErr, o_BootDone, o_BootErr, o_LinkUp;

    sgmii_reg_init_master #(
        .pModeReg(P_MODE), .pLinkTimer(P_LT), .pReg4(P_REG4), .pReg0(P_REG0),
        .pAckTimeout(P_TMO), .pPollGap(P_GAP), .pPollMax(P_PMAX)
    ) dut (
        .i_Clk(i_Clk), .i_RstLogic_L(i_RstLogic_L),
        .o_Cyc(o_Cyc), .o_Stb(o_Stb), .o_WEn(o_WEn), .o8_Addr(o8_Addr),
        .o32_WrData(o32_WrData), .i32_RdData(rd), .i_Ack(ack),
        .i_CmdValid(i_CmdValid), .o_CmdReady(o_CmdReady), .i_CmdWEn(i_CmdWEn),
        .i5_CmdReg(i5_CmdReg), .i16_CmdWrData(i16_CmdWrData),
        .o_RspValid(o_RspValid), .o16_RspData(o16_RspData), .o_RspErr(o_RspErr),
        .o_BootDone(o_BootDone), .o_BootErr(o_BootErr), .o_LinkUp(o_LinkUp)
    );

    always #5 i_Clk = ~i_Clk;

    // Slave: acks after ack_dly sampled Stb-high cycles, never acks block_addr.
    int          ack_dly = 1;
    logic [7:0]  block_addr = 8'hFF;
    logic [15:0] smem [32];
    logic [15:0] status_seq [$];
    logic [15:0] status_now = 16'h002C;
    int          scnt = 0;
    bit          sdone = 1'b0;

    always @(posedge i_Clk) begin
        ack <= 1'b0;
        if (!o_Stb) begin
            scnt  <= 0;
            sdone <= 1'b0;
        end else if (!sdone && o8_Addr != block_addr) begin
            if (scnt + 1 >= ack_dly) begin
                ack   <= 1'b1;
                sdone <= 1'b1;
                if (o_WEn) smem[o8_Addr[6:2]] <= o32_WrData[15:0];
                else if (o8_Addr[6:2] == 5'h01)
                    rd <= {16'($urandom), (status_seq.size() > 0) ? status_seq.pop_front() : status_now};
                else rd <= {16'($urandom), smem[o8_Addr[6:2]]};
            end else scnt <= scnt + 1;
        end
    end

    // Bus monitor: one log entry per Stb rise, Stb-high length per pulse.
    typedef struct {
        logic        wen;
        logic [7:0]  addr;
        logic [31:0] data;
        int          rise;
    } txn_t;
    txn_t txq [$];
    int   hi_q [$];
    int   cur_hi = 0;
    logic stb_prev = 1'b0;
    int   cyc = 0;
    int   rsp_cnt = 0;

    always @(posedge i_Clk) begin
        cyc      <= cyc + 1;
        stb_prev <= o_Stb;
        if (o_RspValid) rsp_cnt <= rsp_cnt + 1;
        if (o_Stb && !stb_prev) begin
            txq.push_back('{o_WEn, o8_Addr, o32_WrData, cyc});
            cur_hi <= 1;
        end else if (o_Stb) cur_hi <= cur_hi + 1;
        else if (stb_prev) hi_q.push_back(cur_hi);
    end

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic link_cond(input logic [15:0] s);
        return s[2] && (s[5] || !P_REG0[12]);
    endfunction

    function automatic logic [15:0] fail_status();
        logic [15:0] s = 16'($urandom);
        if ($urandom_range(0, 1) == 0) s[2] = 1'b0;
        else s[5] = 1'b0;
        return s;
    endfunction

    // Expected boot writes, straight from the register map.
    logic [7:0]  exp_addr [5];
    logic [31:0] exp_data [5];
    logic [15:0] mdl_mem [32];

    task automatic boot_run(input string tag, input int dly, input int nfail, input bit rnd);
        int polls_exp, n, b, rb;
        bit link_exp;
        logic [15:0] pv;
        ack_dly    = dly;
        block_addr = 8'hFF;
        i_RstLogic_L = 1'b0;
        status_seq.delete();
        for (int i = 0; i < nfail; i++) status_seq.push_back(rnd ? fail_status() : 16'h000C);
        pv = rnd ? (16'($urandom) | 16'h0024) : 16'h002C;
        status_seq.push_back(pv);
        status_now = pv;
        repeat (2) @(posedge i_Clk);
        #1;
        b  = txq.size();
        rb = rsp_cnt;
        i_RstLogic_L = 1'b1;
        polls_exp = (nfail < P_PMAX) ? nfail + 1 : P_PMAX;
        link_exp  = (nfail < P_PMAX);
        n = 0;
        while (!o_BootDone && n < 20000) begin
            i_CmdValid = (n < 12);
            i5_CmdReg  = 5'h05;
            @(posedge i_Clk);
            #1;
            n++;
        end
        i_CmdValid = 1'b0;
        chk({tag, " done"}, 32'(o_BootDone), 32'd1);
        chk({tag, " ntxn"}, 32'(txq.size() - b), 32'(5 + polls_exp));
        for (int i = 0; i < 5; i++) begin
            if (b + i < txq.size()) begin
                chk({tag, " wr wen"},  32'(txq[b+i].wen), 32'd1);
                chk({tag, " wr addr"}, 32'(txq[b+i].addr), 32'(exp_addr[i]));
                chk({tag, " wr data"}, txq[b+i].data, exp_data[i]);
            end
        end
        for (int i = 0; i < polls_exp; i++) begin
            if (b + 5 + i < txq.size()) begin
                chk({tag, " poll addr"}, {23'h0, txq[b+5+i].wen, txq[b+5+i].addr}, 32'h04);
                if (i > 0)
                    chk({tag, " poll gap"}, 32'(txq[b+5+i].rise - txq[b+4+i].rise >= P_GAP), 32'd1);
            end
        end
        chk({tag, " linkup"},  32'(o_LinkUp), 32'(link_exp));
        chk({tag, " booterr"}, 32'(o_BootErr), 32'(!link_exp));
        chk({tag, " no rsp"},  32'(rsp_cnt - rb), 32'd0);
        chk({tag, " ready"},   32'(o_CmdReady), 32'd1);
        status_seq.delete();
    endtask

    task automatic host_op(input string tag, input logic w, input logic [4:0] r,
                           input logic [15:0] d, input logic exp_err, input logic [15:0] exp_d);
        int n = 0;
        while (!o_CmdReady && n < 200) begin
            @(posedge i_Clk);
            #1;
            n++;
        end
        chk({tag, " ready"}, 32'(o_CmdReady), 32'd1);
        i_CmdValid = 1'b1;
        i_CmdWEn = w;
        i5_CmdReg = r;
        i16_CmdWrData = d;
        @(posedge i_Clk);
        #1;
        i_CmdValid = 1'b0;
        i_CmdWEn = ~w;
        i5_CmdReg = 5'($urandom);
        i16_CmdWrData = 16'($urandom);
        n = 0;
        while (!o_RspValid && n < 100) begin
            @(posedge i_Clk);
            #1;
            n++;
        end
        chk({tag, " rspv"}, 32'(o_RspValid), 32'd1);
        chk({tag, " err"},  32'(o_RspErr), 32'(exp_err));
        chk({tag, " data"}, 32'(o16_RspData), 32'(exp_d));
        @(posedge i_Clk);
        #1;
        chk({tag, " pulse"},    32'(o_RspValid), 32'd0);
        chk({tag, " ready ret"}, 32'(o_CmdReady), 32'd1);
    endtask

    initial begin
        int n, b;
        logic [4:0]  wr_regs [6];
        logic [15:0] s;
        logic        lu;
        exp_addr = '{8'h7C, 8'h20, 8'h24, 8'h10, 8'h00};
        exp_data = '{{16'h0, P_MODE}, {16'h0, P_LT[15:0]}, {27'h0, P_LT[20:16]},
                     {16'h0, P_REG4}, {16'h0, P_REG0}};

        // Reset state
        repeat (3) @(posedge i_Clk);
        #1;
        chk("rst stb",    {30'h0, o_Cyc, o_Stb}, 32'h0);
        chk("rst wen",    32'(o_WEn), 32'd0);
        chk("rst addr",   32'(o8_Addr), 32'd0);
        chk("rst wdata",  o32_WrData, 32'd0);
        chk("rst ready",  32'(o_CmdReady), 32'd0);
        chk("rst rsp",    {15'h0, o_RspValid, o16_RspData}, 32'd0);
        chk("rst flags",  {28'h0, o_RspErr, o_BootDone, o_BootErr, o_LinkUp}, 32'd0);

        boot_run("boot1", 1, 0, 1'b0);
        boot_run("boot2", 1, 3, 1'b0);
        boot_run("bootr", int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 1'b1);
        boot_run("bootlim", int'($urandom_range(1, 3)), P_PMAX + 1, 1'b1);

        // Host read latency against a 1-cycle slave
        ack_dly = 1;
        host_op("wr5", 1'b1, 5'h05, 16'h41A0, 1'b0, 16'h0000);
        i_CmdValid = 1'b1;
        i_CmdWEn   = 1'b0;
        i5_CmdReg  = 5'h05;
        @(posedge i_Clk);
        #1;
        i_CmdValid = 1'b0;
        i5_CmdReg  = 5'h1F;
        chk("lat T+1 stb",   32'(o_Stb), 32'd1);
        chk("lat T+1 addr",  32'(o8_Addr), 32'h14);
        chk("lat T+1 ready", 32'(o_CmdReady), 32'd0);
        @(posedge i_Clk);
        #1;
        chk("lat T+2 rspv", 32'(o_RspValid), 32'd0);
        @(posedge i_Clk);
        #1;
        chk("lat T+3 rspv", 32'(o_RspValid), 32'd1);
        chk("lat T+3 data", 32'(o16_RspData), 32'h41A0);
        chk("lat T+3 err",  32'(o_RspErr), 32'd0);
        @(posedge i_Clk);
        #1;
        chk("lat T+4 ready", 32'(o_CmdReady), 32'd1);

        // Host write timeout, then retry
        block_addr = 8'h28;
        host_op("wr tmo", 1'b1, 5'h0A, 16'hBEEF, 1'b1, 16'h0000);
        chk("wr tmo stb len", 32'(hi_q[hi_q.size()-1]), 32'(P_TMO));
        block_addr = 8'hFF;
        host_op("wr retry", 1'b1, 5'h0A, 16'hBEEF, 1'b0, 16'h0000);
        host_op("rd 0A", 1'b0, 5'h0A, 16'h0000, 1'b0, 16'hBEEF);

        // Random host writes then read-backs against a model register file
        for (int i = 0; i < 6; i++) begin
            wr_regs[i] = 5'($urandom_range(2, 31));
            mdl_mem[wr_regs[i]] = 16'($urandom);
            ack_dly = int'($urandom_range(1, 6));
            host_op("rnd wr", 1'b1, wr_regs[i], mdl_mem[wr_regs[i]], 1'b0, 16'h0000);
        end
        for (int i = 0; i < 6; i++) begin
            n = int'($urandom_range(0, 5));
            ack_dly = int'($urandom_range(1, 6));
            host_op("rnd rd", 1'b0, wr_regs[n], 16'h0000, 1'b0, mdl_mem[wr_regs[n]]);
        end

        // Host status reads drive LinkUp, host writes do not
        for (int i = 0; i < 4; i++) begin
            s = (i % 2 == 0) ? fail_status() : (16'($urandom) | 16'h0024);
            status_now = s;
            lu = link_cond(s);
            host_op("rd status", 1'b0, 5'h01, 16'h0000, 1'b0, s);
            chk("host linkup", 32'(o_LinkUp), 32'(lu));
        end
        host_op("wr status", 1'b1, 5'h01, 16'h0000, 1'b0, 16'h0000);
        chk("wr keeps linkup", 32'(o_LinkUp), 32'(lu));

        // Boot timeout on the 0x08 write
        ack_dly = 1;
        block_addr = 8'h20;
        i_RstLogic_L = 1'b0;
        repeat (2) @(posedge i_Clk);
        #1;
        b = txq.size();
        i_RstLogic_L = 1'b1;
        n = 0;
        while (!o_BootDone && n < 2000) begin
            @(posedge i_Clk);
            #1;
            n++;
        end
        repeat (60) @(posedge i_Clk);
        #1;
        chk("tmo done",    32'(o_BootDone), 32'd1);
        chk("tmo err",     32'(o_BootErr), 32'd1);
        chk("tmo ntxn",    32'(txq.size() - b), 32'd2);
        chk("tmo stb len", 32'(hi_q[hi_q.size()-1]), 32'(P_TMO));
        chk("tmo ready",   32'(o_CmdReady), 32'd1);
        block_addr = 8'hFF;

        // Reset while Stb is high mid-boot
        ack_dly = 3;
        i_RstLogic_L = 1'b0;
        repeat (2) @(posedge i_Clk);
        #1;
        b = txq.size();
        i_RstLogic_L = 1'b1;
        n = 0;
        while (!(txq.size() - b >= 2 && o_Stb) && n < 200) begin
            @(posedge i_Clk);
            #1;
            n++;
        end
        chk("mid stb high", 32'(o_Stb), 32'd1);
        i_RstLogic_L = 1'b0;
        @(posedge i_Clk);
        #1;
        chk("mid stb drop", {30'h0, o_Cyc, o_Stb}, 32'd0);
        b = txq.size();
        i_RstLogic_L = 1'b1;
        n = 0;
        while (!o_Stb && n < 50) begin
            @(posedge i_Clk);
            #1;
            n++;
        end
        chk("restart stb", 32'(o_Stb), 32'd1);
        chk("restart addr", 32'(o8_Addr), 32'h7C);
        chk("restart data", o32_WrData, 32'h0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
